alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Issue controller between the execute stage and the ALU with its multi-cycle multiplier/divider. Accepts one operation at a time over a valid/ready handshake. Single-cycle ops are registered in one cycle. For mul/div ops the block latches the operands, holds the ALU enable until completion, and presents the registered result with its tag. It also handles pipeline flush and guarantees the enable re-arm gap the mul/div units need between operations.

## Interface
- `TAG_W`, 5: width of the destination tag carried with each op
- `clk` in 1: clock
- `resetn` in 1: synchronous, active-low reset
- `flush` in 1: kill any accepted or in-flight op; takes priority over everything else
- `in_valid` in 1, `in_ready` out 1: request handshake
- `in_ctrl` in 5: ALU op code (common package enum)
- `in_a`, `in_b` in 64: operands
- `in_tag` in TAG_W: destination tag
- `alu_a`, `alu_b` out 64, `alu_ctrl` out 5: ALU operand and op drive
- `alu_en` out 1: mul/div enable
- `alu_result` in 64, `alu_compl` in 1: ALU outputs
- `out_valid` out 1, `out_ready` in 1: result handshake
- `out_result` out 64, `out_tag` out TAG_W: registered result and tag

## Operation
- States: IDLE, BUSY, HOLD.
- Multi-cycle ops are MUL, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW (`is_multi`). All other codes are single-cycle.
- `in_ready` = !flush && (IDLE || (HOLD && out_ready)). This allows back-to-back issue.
- ALU operand mux: `alu_a`/`alu_b`/`alu_ctrl` = latched op_a/op_b/op_ctrl in BUSY, otherwise `in_a`/`in_b`/`in_ctrl` (combinational).
- Accept of a single-cycle op: capture `alu_result` and `in_tag` into the output registers; go to HOLD.
- Accept of a multi-cycle op: latch ctrl, a, b and tag; go to BUSY.
- BUSY: `alu_en` = 1, driven from a register. When `alu_compl` is sampled high: capture `alu_result`, clear `alu_en`, go to HOLD.
- HOLD: `out_valid` = 1 and outputs are stable until `out_ready`.
  - `out_ready` with an accept in the same cycle: follow the accept rules above.
  - `out_ready` with no accept: go to IDLE.
- `alu_en` is low in IDLE and HOLD, so there is at least 1 low cycle between consecutive mul/div ops.
- Flush, any state: next state IDLE; `out_valid` = 0, `alu_en` = 0. An in-flight result is discarded and a same-cycle request is not accepted.
- Reset: state IDLE. `out_valid`, `alu_en`, `out_result`, `out_tag` and all latched registers are 0. `in_ready` is 1 once `resetn` is high.
- Divide-by-zero and overflow values come from the ALU unchanged. The sequencer does not inspect operands except for the cache match.

## Timing
- Single-cycle op accepted at cycle T: `out_valid` at T+1.
- Multi-cycle op accepted at T: `alu_en` high from T+1. If `alu_compl` is first high at cycle C, `out_valid` is at C+1 and `alu_en` is low at C+1.
- A `alu_compl` that is already high at T+1 counts as completion, giving a minimum latency of 2.
- Flush at cycle F: IDLE at F+1, with `out_valid` = 0 and `alu_en` = 0 at F+1.
- Flush wins over `alu_compl` and over `out_ready` in the same cycle.

## Configuration
- `ALU_SEQ_CACHE_EN` defined: a one-entry result cache holding {valid, ctrl, a, b, result}.
  - Written on every multi-cycle completion.
  - A multi-cycle accept whose ctrl/a/b match a valid entry goes directly to HOLD with the cached result (latency 1) and never asserts `alu_en`.
  - The cache is cleared only by reset. A flushed op never writes it.
- Undefined: every multi-cycle op goes through BUSY and there are no cache registers.

## Structure
- Shared package (common): the state enum (IDLE/BUSY/HOLD) and the `is_multi(ctrl)` function. The op-code enum is reused from the package.
- One sub-module, `alu_seq_cache`: the match/store logic, instantiated only under `ALU_SEQ_CACHE_EN`.

## Test plan
- ADD a=3, b=4, accepted at T: `out_valid` at T+1 with result 7 and tag preserved; `alu_en` never high.
- DIV a=100, b=7, with the ALU model completing after 4 cycles: `alu_en` high for T+1..T+4, `out_result` 14 at T+5, `in_ready` low during BUSY.
- DIVU b=0: `out_result` 64'hFFFF_FFFF_FFFF_FFFF; REMU b=0 returns a unchanged.
- Two back-to-back MULs with `out_ready` held low for 3 cycles: the first result stays stable through backpressure; the second is accepted in the `out_ready` cycle; `alu_en` shows a ≥1-cycle low gap.
- Flush on the second BUSY cycle of MUL 6×7: IDLE next cycle, `out_valid` never asserted, `alu_en` low; the following ADD completes normally.
- With `ALU_SEQ_CACHE_EN`: MUL 6×7 then MUL 6×7 again gives 42 at accept+1 with no `alu_en`. MUL 6×8 misses and goes through BUSY.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU issue sequencer: ALU op codes, the
// sequencer state encoding and the multi-cycle op classifier.
package alu_op_sequencer_pkg;

   // ALU operation codes (5-bit), shared with the execute stage and the ALU
   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_ADDW,
      ALU_SUBW,
      ALU_SLLW,
      ALU_SRLW,
      ALU_SRAW,
      ALU_MUL,
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU,
      ALU_MULW,
      ALU_DIV,
      ALU_DIVU,
      ALU_REM,
      ALU_REMU,
      ALU_DIVW,
      ALU_DIVUW,
      ALU_REMW,
      ALU_REMUW
   } alu_op_e;

   // Sequencer states: waiting for work, waiting on mul/div, presenting a result
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } seq_state_e;

   // True for the ops executed by the iterative multiplier/divider.
   // The high-half multiplies are handled by the single-cycle datapath.
   function automatic logic is_multi(input logic [4:0] ctrl);
      case (ctrl)
         ALU_MUL, ALU_MULW,
         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
         ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW: is_multi = 1'b1;
         default:                                 is_multi = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_op_sequencer_cache.sv
// One-entry mul/div result cache used by alu_op_sequencer when
// ALU_SEQ_CACHE_EN is defined. Lookup is combinational, store is registered.
module alu_seq_cache (
   input  logic        clk,
   input  logic        resetn,
   input  logic [4:0]  lookup_ctrl_i,
   input  logic [63:0] lookup_a_i,
   input  logic [63:0] lookup_b_i,
   output logic        hit_o,
   output logic [63:0] hit_result_o,
   input  logic        wr_en_i,
   input  logic [4:0]  wr_ctrl_i,
   input  logic [63:0] wr_a_i,
   input  logic [63:0] wr_b_i,
   input  logic [63:0] wr_result_i
);

   logic        valid_q;
   logic [4:0]  ctrl_q;
   logic [63:0] a_q;
   logic [63:0] b_q;
   logic [63:0] result_q;

   // Overwrite the single entry on every completed mul/div; only reset clears it
   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q  <= 1'b0;
         ctrl_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else if (wr_en_i) begin
         valid_q  <= 1'b1;
         ctrl_q   <= wr_ctrl_i;
         a_q      <= wr_a_i;
         b_q      <= wr_b_i;
         result_q <= wr_result_i;
      end
   end

   assign hit_o        = valid_q && (ctrl_q == lookup_ctrl_i) &&
                         (a_q == lookup_a_i) && (b_q == lookup_b_i);
   assign hit_result_o = result_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue controller between execute and the ALU mul/div units.
// Single-cycle ops complete in one cycle; mul/div ops are latched and the
// ALU enable is held until alu_compl. Flush kills everything.
// Optional feature: define ALU_SEQ_CACHE_EN for a one-entry mul/div result cache.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_ctrl,
   input  logic [63:0]      in_a,
   input  logic [63:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [63:0]      alu_a,
   output logic [63:0]      alu_b,
   output logic [4:0]       alu_ctrl,
   output logic             alu_en,
   input  logic [63:0]      alu_result,
   input  logic             alu_compl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_result,
   output logic [TAG_W-1:0] out_tag
);

   seq_state_e       state_q;
   logic [4:0]       op_ctrl_q;
   logic [63:0]      op_a_q;
   logic [63:0]      op_b_q;
   logic [TAG_W-1:0] op_tag_q;
   logic [63:0]      out_result_q;
   logic [TAG_W-1:0] out_tag_q;
   logic             out_valid_q;
   logic             alu_en_q;

   logic             accept;
   logic             in_multi;
   logic             cache_hit;
   logic [63:0]      cache_result;

   assign in_ready = !flush && ((state_q == ST_IDLE) ||
                                ((state_q == ST_HOLD) && out_ready));
   assign accept   = in_valid && in_ready;
   assign in_multi = is_multi(in_ctrl);

   // While BUSY the ALU sees the latched op; otherwise the incoming op passes
   // straight through so single-cycle results are ready at the accept edge.
   assign alu_a    = (state_q == ST_BUSY) ? op_a_q    : in_a;
   assign alu_b    = (state_q == ST_BUSY) ? op_b_q    : in_b;
   assign alu_ctrl = (state_q == ST_BUSY) ? op_ctrl_q : in_ctrl;

   assign alu_en     = alu_en_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_tag    = out_tag_q;

`ifdef ALU_SEQ_CACHE_EN
   logic cache_wr;

   // A flushed completion never reaches the cache
   assign cache_wr = (state_q == ST_BUSY) && alu_compl && !flush;

   alu_seq_cache u_cache (
      .clk           (clk),
      .resetn        (resetn),
      .lookup_ctrl_i (in_ctrl),
      .lookup_a_i    (in_a),
      .lookup_b_i    (in_b),
      .hit_o         (cache_hit),
      .hit_result_o  (cache_result),
      .wr_en_i       (cache_wr),
      .wr_ctrl_i     (op_ctrl_q),
      .wr_a_i        (op_a_q),
      .wr_b_i        (op_b_q),
      .wr_result_i   (alu_result)
   );
`else
   assign cache_hit    = 1'b0;
   assign cache_result = '0;
`endif

   // Sequencer FSM with registered enable, valid, result and tag
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         op_ctrl_q    <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_tag_q     <= '0;
         out_result_q <= '0;
         out_tag_q    <= '0;
         out_valid_q  <= 1'b0;
         alu_en_q     <= 1'b0;
      end else if (flush) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         alu_en_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_BUSY: begin
               if (alu_compl) begin
                  out_result_q <= alu_result;
                  out_tag_q    <= op_tag_q;
                  out_valid_q  <= 1'b1;
                  alu_en_q     <= 1'b0;
                  state_q      <= ST_HOLD;
               end
            end
            ST_IDLE, ST_HOLD: begin
               if (accept) begin
                  if (!in_multi || cache_hit) begin
                     out_result_q <= in_multi ? cache_result : alu_result;
                     out_tag_q    <= in_tag;
                     out_valid_q  <= 1'b1;
                     state_q      <= ST_HOLD;
                  end else begin
                     op_ctrl_q   <= in_ctrl;
                     op_a_q      <= in_a;
                     op_b_q      <= in_b;
                     op_tag_q    <= in_tag;
                     out_valid_q <= 1'b0;
                     alu_en_q    <= 1'b1;
                     state_q     <= ST_BUSY;
                  end
               end else if ((state_q == ST_HOLD) && out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               alu_en_q    <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a behavioural ALU whose
// mul/div completion latency is programmable per operation.
// Cache-specific checks are enabled when ALU_SEQ_CACHE_EN is defined.
module tb_alu_op_sequencer;
   import alu_op_sequencer_pkg::*;

   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             resetn;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_ctrl;
   logic [63:0]      in_a;
   logic [63:0]      in_b;
   logic [TAG_W-1:0] in_tag;
   logic [63:0]      alu_a;
   logic [63:0]      alu_b;
   logic [4:0]       alu_ctrl;
   logic             alu_en;
   logic [63:0]      alu_result;
   logic             alu_compl;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_result;
   logic [TAG_W-1:0] out_tag;

   int n_vec = 0;
   int n_err = 0;
   int lat   = 1;
   int en_cnt = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.TAG_W(TAG_W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ctrl    (in_ctrl),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_en     (alu_en),
      .alu_result (alu_result),
      .alu_compl  (alu_compl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   // Behavioural ALU: combinational result, completion after lat enabled cycles
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         ALU_ADD:  alu_result = alu_a + alu_b;
         ALU_SUB:  alu_result = alu_a - alu_b;
         ALU_MUL:  alu_result = alu_a * alu_b;
         ALU_DIV:  alu_result = (alu_b == 0) ? '1 : 64'($signed(alu_a) / $signed(alu_b));
         ALU_DIVU: alu_result = (alu_b == 0) ? '1 : alu_a / alu_b;
         ALU_REMU: alu_result = (alu_b == 0) ? alu_a : alu_a % alu_b;
         default:  alu_result = '0;
      endcase
   end

   assign alu_compl = alu_en && (en_cnt == lat - 1);

   always @(posedge clk) en_cnt <= alu_en ? en_cnt + 1 : 0;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] t, input string tag);
      in_valid = 1'b1;
      in_ctrl  = c;
      in_a     = a;
      in_b     = b;
      in_tag   = t;
      #1;
      $display("issue %s ctrl=%0d a=%0d b=%0d tag=%0d", tag, c, a, b, t);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int max_cyc, input string tag);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < max_cyc) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_released"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      resetn    = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_ctrl   = ALU_ADD;
      in_a      = '0;
      in_b      = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_alu_en", 64'(alu_en), 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      resetn = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // ADD 3+4: result one cycle after accept, no enable
      issue(ALU_ADD, 64'd3, 64'd4, 5'd5, "add");
      chk("add_valid", 64'(out_valid), 64'd1);
      chk("add_result", out_result, 64'd7);
      chk("add_tag", 64'(out_tag), 64'd5);
      chk("add_alu_en", 64'(alu_en), 64'd0);
      chk("add_in_ready_bp", 64'(in_ready), 64'd0);
      release_out("add");

      // DIV 100/7 with 4-cycle ALU latency; operands latched against input changes
      lat = 4;
      issue(ALU_DIV, 64'd100, 64'd7, 5'd9, "div");
      in_a = 64'd555;
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk($sformatf("div_en_%0d", k), 64'(alu_en), 64'd1);
         chk($sformatf("div_rdy_%0d", k), 64'(in_ready), 64'd0);
         chk($sformatf("div_ov_%0d", k), 64'(out_valid), 64'd0);
         chk($sformatf("div_alu_a_%0d", k), alu_a, 64'd100);
         step();
      end
      chk("div_valid", 64'(out_valid), 64'd1);
      chk("div_result", out_result, 64'd14);
      chk("div_tag", 64'(out_tag), 64'd9);
      chk("div_en_off", 64'(alu_en), 64'd0);
      release_out("div");

      // Divide-by-zero values pass through from the ALU
      lat = 2;
      issue(ALU_DIVU, 64'd5, 64'd0, 5'd1, "divu0");
      wait_valid(10, "divu0");
      chk("divu0_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
      release_out("divu0");
      issue(ALU_REMU, 64'd123, 64'd0, 5'd2, "remu0");
      wait_valid(10, "remu0");
      chk("remu0_result", out_result, 64'd123);
      release_out("remu0");

      // Minimum latency: completion already high on the first BUSY cycle
      lat = 1;
      issue(ALU_MUL, 64'd2, 64'd3, 5'd3, "minlat");
      chk("minlat_en", 64'(alu_en), 64'd1);
      chk("minlat_ov", 64'(out_valid), 64'd0);
      step();
      chk("minlat_valid", 64'(out_valid), 64'd1);
      chk("minlat_result", out_result, 64'd6);
      chk("minlat_en_off", 64'(alu_en), 64'd0);
      release_out("minlat");

      // Back-to-back MULs under backpressure
      lat = 3;
      issue(ALU_MUL, 64'd3, 64'd5, 5'd1, "mul1");
      wait_valid(10, "mul1");
      in_valid = 1'b1;
      in_ctrl  = ALU_MUL;
      in_a     = 64'd4;
      in_b     = 64'd5;
      in_tag   = 5'd2;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp_rdy_%0d", k), 64'(in_ready), 64'd0);
         chk($sformatf("bp_ov_%0d", k), 64'(out_valid), 64'd1);
         chk($sformatf("bp_res_%0d", k), out_result, 64'd15);
         chk($sformatf("bp_tag_%0d", k), 64'(out_tag), 64'd1);
         chk($sformatf("bp_gap_%0d", k), 64'(alu_en), 64'd0);
         step();
      end
      out_ready = 1'b1;
      #1;
      $display("issue mul2 ctrl=%0d a=4 b=5 tag=2 (in out_ready cycle)", ALU_MUL);
      chk("mul2_in_ready", 64'(in_ready), 64'd1);
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("mul2_ov", 64'(out_valid), 64'd0);
      chk("mul2_en", 64'(alu_en), 64'd1);
      chk("mul2_alu_a", alu_a, 64'd4);
      wait_valid(10, "mul2");
      chk("mul2_result", out_result, 64'd20);
      chk("mul2_tag", 64'(out_tag), 64'd2);

      // Single-cycle op accepted while HOLD is draining
      out_ready = 1'b1;
      issue(ALU_ADD, 64'd10, 64'd20, 5'd3, "add_b2b");
      out_ready = 1'b0;
      chk("add_b2b_valid", 64'(out_valid), 64'd1);
      chk("add_b2b_result", out_result, 64'd30);
      chk("add_b2b_tag", 64'(out_tag), 64'd3);
      release_out("add_b2b");

      // Flush on the second BUSY cycle of MUL 6x7
      lat = 4;
      issue(ALU_MUL, 64'd6, 64'd7, 5'd7, "mulfl");
      step();
      flush = 1'b1;
      #1;
      chk("fl_in_ready", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0;
      #1;
      chk("fl_en", 64'(alu_en), 64'd0);
      chk("fl_ov", 64'(out_valid), 64'd0);
      chk("fl_idle_rdy", 64'(in_ready), 64'd1);
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("fl_quiet_%0d", k), 64'({out_valid, alu_en}), 64'd0);
      end
      issue(ALU_ADD, 64'd1, 64'd2, 5'd4, "add_postfl");
      chk("add_postfl_result", out_result, 64'd3);
      chk("add_postfl_valid", 64'(out_valid), 64'd1);

      // Flush beats out_ready and a same-cycle request
      flush     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = ALU_SUB;
      in_a      = 64'd9;
      in_b      = 64'd1;
      step();
      flush     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("flreq_ov", 64'(out_valid), 64'd0);
      chk("flreq_en", 64'(alu_en), 64'd0);
      chk("flreq_result_kept", out_result, 64'd3);

      // MUL 6x7 again must miss: the flushed op left no cache entry
      lat = 3;
      issue(ALU_MUL, 64'd6, 64'd7, 5'd6, "mul67a");
      chk("mul67a_en", 64'(alu_en), 64'd1);
      wait_valid(10, "mul67a");
      chk("mul67a_result", out_result, 64'd42);
      release_out("mul67a");

      issue(ALU_MUL, 64'd6, 64'd7, 5'd8, "mul67b");
`ifdef ALU_SEQ_CACHE_EN
      chk("mul67b_hit_en", 64'(alu_en), 64'd0);
      chk("mul67b_hit_valid", 64'(out_valid), 64'd1);
      chk("mul67b_hit_result", out_result, 64'd42);
      chk("mul67b_hit_tag", 64'(out_tag), 64'd8);
`else
      chk("mul67b_en", 64'(alu_en), 64'd1);
      wait_valid(10, "mul67b");
      chk("mul67b_result", out_result, 64'd42);
`endif
      release_out("mul67b");

      issue(ALU_MUL, 64'd6, 64'd8, 5'd10, "mul68");
      chk("mul68_en", 64'(alu_en), 64'd1);
      chk("mul68_ov", 64'(out_valid), 64'd0);
      wait_valid(10, "mul68");
      chk("mul68_result", out_result, 64'd48);
      chk("mul68_tag", 64'(out_tag), 64'd10);
      release_out("mul68");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
